// File: rtl/timer_pkg.sv
// Shared timer definitions: TDR register offsets, read-FSM states and the data word type.
// Used by both the read path (cnt_reader) and the counter write decode.
package timer_pkg;

  localparam logic [11:0] TIM_TDR0_OFS = 12'h004;
  localparam logic [11:0] TIM_TDR1_OFS = 12'h008;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } rd_state_e;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/cnt_snapshot.sv
// High-word shadow for coherent 64-bit counter reads; only built when TIM_RD_SNAPSHOT_EN is defined.
// A TDR0 read loads the shadow, a TDR1 read consumes it, and any counter write invalidates it.
`ifdef TIM_RD_SNAPSHOT_EN
module cnt_snapshot
  import timer_pkg::*;
(
  input  logic  sys_clk,
  input  logic  sys_rst,
  input  logic  cap_lo,
  input  logic  cap_hi,
  input  logic  inval,
  input  word_t cnt_hi,
  output word_t hi_word
);

  word_t shadow;
  logic  snap_vld;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shadow   <= '0;
      snap_vld <= 1'b0;
    end else begin
      if (cap_lo) begin
        shadow <= cnt_hi;
      end
      // A counter write makes any pending snapshot stale, even one taken on this same edge.
      if (inval) begin
        snap_vld <= 1'b0;
      end else if (cap_lo) begin
        snap_vld <= 1'b1;
      end else if (cap_hi) begin
        snap_vld <= 1'b0;
      end
    end
  end

  assign hi_word = snap_vld ? shadow : cnt_hi;

endmodule
`endif

// File: rtl/cnt_reader.sv
// Bus read path for TDR0/TDR1 of the 64-bit timer counter: one wait state, registered response.
// Define TIM_RD_SNAPSHOT_EN to make TDR0-then-TDR1 sequences return a coherent 64-bit value.
module cnt_reader
  import timer_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] TDR0_OFS = ADDR_W'(TIM_TDR0_OFS),
  parameter logic [ADDR_W-1:0] TDR1_OFS = ADDR_W'(TIM_TDR1_OFS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [63:0]       cnt,
  input  logic              tdr0_wr_sel,
  input  logic              tdr1_wr_sel,
  input  logic              tim_psel,
  input  logic              tim_penable,
  input  logic              tim_pwrite,
  input  logic [ADDR_W-1:0] tim_paddr,
  output logic [31:0]       tim_prdata,
  output logic              tim_pready,
  output logic              tim_pslverr
);

  rd_state_e state;
  rd_state_e state_nxt;
  word_t     prdata_q;
  logic      err_q;
  word_t     hi_word;
  logic      rd_setup;
  logic      rd_accept;
  logic      hit_tdr0;
  logic      hit_tdr1;

  assign rd_setup  = tim_psel & ~tim_penable & ~tim_pwrite;
  assign rd_accept = (state == IDLE) & rd_setup;
  assign hit_tdr0  = (tim_paddr == TDR0_OFS);
  assign hit_tdr1  = (tim_paddr == TDR1_OFS);

`ifdef TIM_RD_SNAPSHOT_EN
  cnt_snapshot u_snapshot (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cap_lo  (rd_accept & hit_tdr0),
    .cap_hi  (rd_accept & hit_tdr1),
    .inval   (tdr0_wr_sel | tdr1_wr_sel),
    .cnt_hi  (cnt[63:32]),
    .hi_word (hi_word)
  );
`else
  logic unused_wr_sel;
  assign unused_wr_sel = tdr0_wr_sel ^ tdr1_wr_sel;
  assign hi_word       = cnt[63:32];
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rd_setup) state_nxt = CAPT;
      CAPT: begin
        if (!tim_psel) begin
          state_nxt = IDLE;
        end else if (tim_penable) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tim_pready  = 1'b0;
    tim_prdata  = '0;
    tim_pslverr = 1'b0;
    if (state == RESP) begin
      tim_pready  = 1'b1;
      tim_prdata  = prdata_q;
      tim_pslverr = err_q;
    end
  end

  // Setup-phase capture: data is cnt as sampled at the end of the setup cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else if (rd_accept) begin
      if (hit_tdr0) begin
        prdata_q <= cnt[31:0];
        err_q    <= 1'b0;
      end else if (hit_tdr1) begin
        prdata_q <= hi_word;
        err_q    <= 1'b0;
      end else begin
        prdata_q <= '0;
        err_q    <= 1'b1;
      end
    end else if (state == RESP) begin
      prdata_q <= '0;
      err_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_reader.sv
// Scoreboard bench for cnt_reader: reads push expected {pslverr, prdata}, a monitor pops on tim_pready.
// Expected values follow TIM_RD_SNAPSHOT_EN when the bench is built with it.
module tb_cnt_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [63:0] cnt = '0;
  logic        tdr0_wr_sel = 1'b0;
  logic        tdr1_wr_sel = 1'b0;
  logic        tim_psel = 1'b0;
  logic        tim_penable = 1'b0;
  logic        tim_pwrite = 1'b0;
  logic [11:0] tim_paddr = '0;
  logic [31:0] tim_prdata;
  logic        tim_pready;
  logic        tim_pslverr;

  int n_pass  = 0;
  int n_total = 0;
  logic [32:0] exp_q[$];

  cnt_reader dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cnt         (cnt),
    .tdr0_wr_sel (tdr0_wr_sel),
    .tdr1_wr_sel (tdr1_wr_sel),
    .tim_psel    (tim_psel),
    .tim_penable (tim_penable),
    .tim_pwrite  (tim_pwrite),
    .tim_paddr   (tim_paddr),
    .tim_prdata  (tim_prdata),
    .tim_pready  (tim_pready),
    .tim_pslverr (tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: every response must match the oldest expectation; idle outputs must be zero.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (tim_pready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pready", {1'b1, tim_pslverr, tim_prdata}, {1'b0, 33'h0});
        end else begin
          check("resp", {1'b1, tim_pslverr, tim_prdata}, {1'b1, exp_q.pop_front()});
        end
      end else begin
        check("idle_zero", {tim_pready, tim_pslverr, tim_prdata}, 34'h0);
      end
    end
  end

  // Full read: setup, access (wait state), response, then one idle cycle.
  task automatic rd(input logic [11:0] addr, input logic err, input logic [31:0] data);
    @(negedge sys_clk);
    tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = 1'b0; tim_paddr = addr;
    exp_q.push_back({err, data});
    @(negedge sys_clk);
    tim_penable = 1'b1;
    @(negedge sys_clk);
    tim_psel = 1'b0; tim_penable = 1'b0;
  endtask

  localparam logic [11:0] A0 = 12'h004;
  localparam logic [11:0] A1 = 12'h008;

  initial begin
    logic [31:0] carry_hi;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", {tim_pready, tim_pslverr, tim_prdata}, 34'h0);
    sys_rst = 1'b0;

    cnt = 64'h0000_0001_2345_6789;
    rd(A0, 1'b0, 32'h2345_6789);

    // Carry between the two halves of a 64-bit read.
    cnt = 64'h0000_0000_FFFF_FFFF;
    rd(A0, 1'b0, 32'hFFFF_FFFF);
    cnt = 64'h0000_0001_0000_0000;
`ifdef TIM_RD_SNAPSHOT_EN
    carry_hi = 32'h0000_0000;
`else
    carry_hi = 32'h0000_0001;
`endif
    rd(A1, 1'b0, carry_hi);

    // Plain TDR1 read with no pending snapshot returns live high word.
    cnt = 64'h1234_5678_9ABC_DEF0;
    rd(A1, 1'b0, 32'h1234_5678);

    // Counter write between TDR0 and TDR1 invalidates the snapshot.
    cnt = 64'h0000_0003_0000_0010;
    rd(A0, 1'b0, 32'h0000_0010);
    @(negedge sys_clk); tdr1_wr_sel = 1'b1;
    @(negedge sys_clk); tdr1_wr_sel = 1'b0;
    cnt = 64'h0000_0007_0000_0020;
    rd(A1, 1'b0, 32'h0000_0007);

    // Write strobe on the same edge as a TDR0 capture leaves the snapshot invalid.
    cnt = 64'h0000_0044_0000_0030;
    @(negedge sys_clk);
    tim_psel = 1'b1; tim_penable = 1'b0; tim_pwrite = 1'b0; tim_paddr = A0;
    tdr0_wr_sel = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_0030});
    @(negedge sys_clk); tim_penable = 1'b1; tdr0_wr_sel = 1'b0;
    @(negedge sys_clk); tim_psel = 1'b0; tim_penable = 1'b0;
    cnt = 64'h0000_0055_0000_0031;
    rd(A1, 1'b0, 32'h0000_0055);

    // Unmapped address: error response with zero data.
    rd(12'h010, 1'b1, 32'h0);

    // Writes are never claimed.
    @(negedge sys_clk);
    tim_psel = 1'b1; tim_pwrite = 1'b1; tim_paddr = A0;
    @(negedge sys_clk); tim_penable = 1'b1;
    @(negedge sys_clk); tim_penable = 1'b0;
    @(negedge sys_clk); tim_psel = 1'b0; tim_pwrite = 1'b0;

    // Abort in the wait state, then an immediate TDR0 read.
    cnt = 64'h0000_0009_0000_0ABC;
    @(negedge sys_clk);
    tim_psel = 1'b1; tim_penable = 1'b0; tim_paddr = A0;
    @(negedge sys_clk);
    tim_psel = 1'b0;
    cnt = 64'h0000_0009_0000_0DEF;
    rd(A0, 1'b0, 32'h0000_0DEF);

    // Reset mid-transfer drops the read and clears the snapshot.
    cnt = 64'h0000_00AA_0000_0001;
    @(negedge sys_clk);
    tim_psel = 1'b1; tim_penable = 1'b0; tim_paddr = A0;
    @(negedge sys_clk);
    sys_rst = 1'b1; tim_psel = 1'b0;
    @(negedge sys_clk);
    check("rst_mid_outputs", {tim_pready, tim_pslverr, tim_prdata}, 34'h0);
    sys_rst = 1'b0;
    cnt = 64'h0000_00BB_0000_0002;
    rd(A1, 1'b0, 32'h0000_00BB);

    repeat (4) @(negedge sys_clk);
    check("missing_responses", 34'(exp_q.size()), 34'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
